// File: rtl/bx_proc_sequencer.sv
// bx_proc_sequencer
//   Per-bx sequencer for the mem1 + mem2 -> memout processing chain. A bx
//   change (with en_proc high) starts an event: both input BRAMs are swept
//   over NENTRIES addresses, and each read is tagged with {valid, page,
//   entry}. When the tag leaves the READ_LATENCY-deep pipe, the element-wise
//   sum is written to memout page bx[0].
//
//   Optional macro: PROC_SEQ_CHECKSUM_EN
//     Defined: XOR checksum of the words written in the last completed event.
//     Undefined: checksum is tied to 0.
//
// Ports
//   clk, reset (async, active low)    clock / reset
//   en_proc                           processing enable
//   bx_in                             current bx; a change starts an event
//   mem1_enb/readaddr/dout            mem1 read port
//   mem2_enb/readaddr/dout            mem2 read port
//   memout_ena/wea/writeaddr/din      memout write port, writeaddr = {page, entry}
//   bx_out                            bx of the last completed event
//   done                              1-cycle pulse after the final write of an event
//   truncated                         1-cycle pulse when an event is cut short
//   checksum                          XOR of the words written in the last event
module bx_proc_sequencer #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int NENTRIES     = 32,
  parameter int READ_LATENCY = 2,
  parameter int BX_WIDTH     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_proc,
  input  logic [BX_WIDTH-1:0]   bx_in,
  output logic                  mem1_enb,
  output logic [ADDR_WIDTH-1:0] mem1_readaddr,
  input  logic [DATA_WIDTH-1:0] mem1_dout,
  output logic                  mem2_enb,
  output logic [ADDR_WIDTH-1:0] mem2_readaddr,
  input  logic [DATA_WIDTH-1:0] mem2_dout,
  output logic                  memout_ena,
  output logic                  memout_wea,
  output logic [ADDR_WIDTH:0]   memout_writeaddr,
  output logic [DATA_WIDTH-1:0] memout_din,
  output logic [BX_WIDTH-1:0]   bx_out,
  output logic                  done,
  output logic                  truncated,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam int L = READ_LATENCY;

  logic [1:0]            state;
  logic [BX_WIDTH-1:0]   bx_prev;
  logic [BX_WIDTH-1:0]   ev_bx;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  page;

  // Read tag pipe: stage L lines up with valid BRAM data.
  // cur marks tags that belong to the event still in progress; a new start
  // clears it so old-event writes neither complete nor checksum the new one.
  logic [L:1]                 vld_pipe;
  logic [L:1]                 pg_pipe;
  logic [L:1]                 cur_pipe;
  logic [L:1]                 last_pipe;
  logic [L:1][ADDR_WIDTH-1:0] addr_pipe;
  logic                       wcur, wlast;

  logic bx_chg, start, issue, is_last, pipe_busy, fin;

  always_comb begin
    bx_chg    = (bx_in != bx_prev);
    start     = bx_chg && en_proc;
    // A start outranks the terminal count and stops reads in the same cycle.
    issue     = (state == RUN) && !start;
    is_last   = (cnt == ADDR_WIDTH'(NENTRIES - 1));
    pipe_busy = |vld_pipe;
    fin       = memout_wea && wcur && wlast;
  end

  assign mem1_enb      = issue;
  assign mem2_enb      = issue;
  assign mem1_readaddr = cnt;
  assign mem2_readaddr = cnt;
  assign memout_ena    = memout_wea;

  // Control FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bx_prev   <= '0;
      ev_bx     <= '0;
      cnt       <= '0;
      page      <= 1'b0;
      truncated <= 1'b0;
    end else begin
      truncated <= 1'b0;
      // bx_prev follows bx_in even while disabled, so a change seen with
      // en_proc low is absorbed rather than started later.
      if (bx_chg) bx_prev <= bx_in;
      if (start) begin
        // Cut short only if the old event still has work outstanding; a
        // start on the cycle of its final write lets it complete.
        truncated <= (state == RUN) || ((state == DRAIN) && pipe_busy);
        state     <= RUN;
        cnt       <= '0;
        page      <= bx_in[0];
        ev_bx     <= bx_in;
      end else begin
        case (state)
          RUN: begin
            if (!en_proc || is_last) begin
              state <= DRAIN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + ADDR_WIDTH'(1);
            end
          end
          DRAIN:   if (!pipe_busy) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Tag pipe and write stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe         <= '0;
      pg_pipe          <= '0;
      cur_pipe         <= '0;
      last_pipe        <= '0;
      addr_pipe        <= '0;
      memout_wea       <= 1'b0;
      memout_writeaddr <= '0;
      memout_din       <= '0;
      wcur             <= 1'b0;
      wlast            <= 1'b0;
      done             <= 1'b0;
      bx_out           <= '0;
    end else begin
      vld_pipe[1]  <= issue;
      pg_pipe[1]   <= page;
      addr_pipe[1] <= cnt;
      cur_pipe[1]  <= issue;
      // Dropping en_proc on the final read still forfeits done.
      last_pipe[1] <= issue && is_last && en_proc;
      for (int i = 2; i <= L; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        pg_pipe[i]   <= pg_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
        cur_pipe[i]  <= cur_pipe[i-1] && !start;
        last_pipe[i] <= last_pipe[i-1];
      end

      memout_wea <= vld_pipe[L];
      wcur       <= vld_pipe[L] && cur_pipe[L] && !start;
      wlast      <= last_pipe[L];
      if (vld_pipe[L]) begin
        memout_writeaddr <= {pg_pipe[L], addr_pipe[L]};
        memout_din       <= mem1_dout + mem2_dout;
      end

      done <= fin;
      // ev_bx is still the finishing event's bx even if a start coincides.
      if (fin) bx_out <= ev_bx;
    end
  end

`ifdef PROC_SEQ_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] ck_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ck_acc   <= '0;
      checksum <= '0;
    end else begin
      if (start)                    ck_acc <= '0;
      else if (memout_wea && wcur)  ck_acc <= ck_acc ^ memout_din;
      // Include the final word being written this cycle.
      if (fin) checksum <= ck_acc ^ memout_din;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_bx_proc_sequencer.sv
module tb_bx_proc_sequencer;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NE = 32;
  localparam int L  = 2;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en_proc = 1'b1;
  logic [BW-1:0] bx_in = '0;
  logic          mem1_enb, mem2_enb;
  logic [AW-1:0] mem1_readaddr, mem2_readaddr;
  logic [DW-1:0] mem1_dout, mem2_dout;
  logic          memout_ena, memout_wea;
  logic [AW:0]   memout_writeaddr;
  logic [DW-1:0] memout_din;
  logic [BW-1:0] bx_out;
  logic          done, truncated;
  logic [DW-1:0] checksum;

  bx_proc_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NENTRIES(NE), .READ_LATENCY(L), .BX_WIDTH(BW)
  ) dut (
    .clk(clk), .reset(reset), .en_proc(en_proc), .bx_in(bx_in),
    .mem1_enb(mem1_enb), .mem1_readaddr(mem1_readaddr), .mem1_dout(mem1_dout),
    .mem2_enb(mem2_enb), .mem2_readaddr(mem2_readaddr), .mem2_dout(mem2_dout),
    .memout_ena(memout_ena), .memout_wea(memout_wea),
    .memout_writeaddr(memout_writeaddr), .memout_din(memout_din),
    .bx_out(bx_out), .done(done), .truncated(truncated), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // Input BRAM models: registered output, L cycles from enb/addr to dout
  logic [DW-1:0] m1 [2**AW];
  logic [DW-1:0] m2 [2**AW];
  logic [DW-1:0] r1 [L];
  logic [DW-1:0] r2 [L];
  always @(posedge clk) begin
    r1[0] <= m1[mem1_readaddr];
    r2[0] <= m2[mem2_readaddr];
    for (int i = 1; i < L; i++) begin
      r1[i] <= r1[i-1];
      r2[i] <= r2[i-1];
    end
  end
  assign mem1_dout = r1[L-1];
  assign mem2_dout = r2[L-1];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [AW:0]   a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t           sbq[$];
  wr_t           e_mon;
  logic [DW-1:0] exp_ck = '0;
  int            done_cnt = 0;
  int            trunc_cnt = 0;

  // Expected writes for entries 0..n-1 of a page; a full event also sets
  // the expected checksum.
  task automatic push_ev(input logic pg, input int n, input bit full);
    logic [DW-1:0] ck;
    wr_t w;
    ck = '0;
    for (int k = 0; k < n; k++) begin
      w.a = {pg, AW'(k)};
      w.d = m1[k] + m2[k];
      ck  = ck ^ w.d;
      sbq.push_back(w);
    end
    if (full) exp_ck = ck;
  endtask

  always @(negedge clk) begin
    if (memout_wea) begin
      if (sbq.size() == 0) chk("unexpected_write", 64'(memout_writeaddr), 64'hFFFF);
      else begin
        e_mon = sbq.pop_front();
        chk("wr_addr", 64'(memout_writeaddr), 64'(e_mon.a));
        chk("wr_data", 64'(memout_din), 64'(e_mon.d));
      end
      chk("ena_eq_wea", 64'(memout_ena), 64'(1));
    end
    if (done)      done_cnt++;
    if (truncated) trunc_cnt++;
  end

  task automatic kick(input logic [BW-1:0] b);
    @(negedge clk);
    bx_in = b;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_ck();
`ifdef PROC_SEQ_CHECKSUM_EN
    chk("checksum", 64'(checksum), 64'(exp_ck));
`else
    chk("checksum_tied0", 64'(checksum), 64'(0));
`endif
  endtask

  int lat, d0, t0;

  initial begin
    for (int k = 0; k < 2**AW; k++) begin
      m1[k] = 32'd5;
      m2[k] = 32'd7;
    end
    for (int i = 0; i < L; i++) begin
      r1[i] = '0;
      r2[i] = '0;
    end

    // Reset state
    wait_cyc(3);
    chk("rst_enb1", 64'(mem1_enb), 0);
    chk("rst_enb2", 64'(mem2_enb), 0);
    chk("rst_raddr1", 64'(mem1_readaddr), 0);
    chk("rst_raddr2", 64'(mem2_readaddr), 0);
    chk("rst_wea", 64'(memout_wea), 0);
    chk("rst_ena", 64'(memout_ena), 0);
    chk("rst_waddr", 64'(memout_writeaddr), 0);
    chk("rst_din", 64'(memout_din), 0);
    chk("rst_bx_out", 64'(bx_out), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_trunc", 64'(truncated), 0);
    chk("rst_checksum", 64'(checksum), 0);
    reset = 1'b1;
    wait_cyc(3);

    // bx 0->2: page 0
    kick(2'd2); push_ev(1'b0, NE, 1'b1);
    wait_cyc(NE + L + 8);

    // bx 2->3: page 1, first-write latency, done, bx_out
    d0 = done_cnt;
    kick(2'd3); push_ev(1'b1, NE, 1'b1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (memout_wea) begin lat = k; break; end
    end
    chk("first_wr_latency", 64'(lat), 64'(L + 2));
    wait_cyc(NE + L + 8);
    chk("done_once_bx3", 64'(done_cnt - d0), 1);
    chk("bx_out_3", 64'(bx_out), 3);
    chk("sb_empty_bx3", 64'(sbq.size()), 0);
    chk_ck();

    // bx 3->0: page 0 again
    kick(2'd0); push_ev(1'b0, NE, 1'b1);
    wait_cyc(NE + L + 8);
    chk("bx_out_0", 64'(bx_out), 0);
    chk("sb_empty_bx0", 64'(sbq.size()), 0);

    // Carry dropped at entry 4
    m1[4] = 32'hFFFF_FFFF; m2[4] = 32'd1;
    kick(2'd1); push_ev(1'b1, NE, 1'b1);
    wait_cyc(NE + L + 8);
    chk("bx_out_1", 64'(bx_out), 1);
    chk("sb_empty_carry", 64'(sbq.size()), 0);
    chk_ck();

    // Truncation: change bx while cnt=10; entries 0..9 to old page
    m1[0] = 32'd1;
    d0 = done_cnt; t0 = trunc_cnt;
    kick(2'd2); push_ev(1'b0, 10, 1'b0);
    wait_cyc(11);
    bx_in = 2'd3; push_ev(1'b1, NE, 1'b1);
    wait_cyc(NE + L + 8);
    chk("trunc_pulse", 64'(trunc_cnt - t0), 1);
    chk("done_once_trunc", 64'(done_cnt - d0), 1);
    chk("bx_out_after_trunc", 64'(bx_out), 3);
    chk("sb_empty_trunc", 64'(sbq.size()), 0);
    chk_ck();

    // en_proc dropped while cnt=5: read 5 still issued, then enables fall
    d0 = done_cnt; t0 = trunc_cnt;
    kick(2'd0); push_ev(1'b0, 6, 1'b0);
    wait_cyc(6);
    en_proc = 1'b0;
    #1 chk("enb_still_on", 64'(mem1_enb), 1);
    @(negedge clk);
    chk("enb_off_next", 64'(mem1_enb), 0);
    chk("enb2_off_next", 64'(mem2_enb), 0);
    wait_cyc(L + 8);
    chk("no_done_en_drop", 64'(done_cnt - d0), 0);
    chk("no_trunc_en_drop", 64'(trunc_cnt - t0), 0);
    chk("bx_out_hold", 64'(bx_out), 3);
    chk("sb_empty_en_drop", 64'(sbq.size()), 0);
    chk_ck();
    en_proc = 1'b1;
    wait_cyc(4);

    // Async reset while cnt=10: writes for entries 0..(10-L-1) already seen
    d0 = done_cnt;
    kick(2'd1); push_ev(1'b1, 10 - L, 1'b0);
    wait_cyc(11);
    #2 reset = 1'b0;
    #1;
    chk("arst_wea", 64'(memout_wea), 0);
    chk("arst_enb", 64'(mem1_enb), 0);
    chk("arst_waddr", 64'(memout_writeaddr), 0);
    chk("arst_din", 64'(memout_din), 0);
    chk("arst_bx_out", 64'(bx_out), 0);
    chk("arst_checksum", 64'(checksum), 0);
    en_proc = 1'b0; bx_in = 2'd0;
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(NE + L + 8);
    chk("sb_empty_arst", 64'(sbq.size()), 0);
    chk("no_done_arst", 64'(done_cnt - d0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
